axi_rd_arbiter: RTL and testbench

//  Shares the single downstream AXI4 read channel between two masters: the instruction fetch path (icache refill, port s0)
//  and the load/store unit (port s1).

---
 rtl/axi_rd_arbiter_if.sv | 41 ++++
 rtl/axi_rd_arbiter.sv | 136 +++++++++++++
 tb/tb_axi_rd_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AXI4 read address/data channel bundle
//
// Purpose: one AXI4 read link (AR + R channels). Used for both upstream
// master ports of the arbiter and its single downstream port.
// Ports (signals):
//   arvalid/arready, araddr[ADDR_WIDTH], arid[ID_WIDTH], arlen[8],
//   arsize[3], arburst[2]                  read address channel
//   rvalid/rready, rdata[DATA_WIDTH], rresp[2], rlast, rid[ID_WIDTH]
//                                          read data channel
// Modports:
//   master - issues AR, accepts R (drives ar*, rready)
//   slave  - accepts AR, returns R (drives arready, r* except rready)
interface axi_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [ID_WIDTH-1:0]   arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [ID_WIDTH-1:0]   rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin arbiter sharing one AXI4 read channel
//
// Purpose: shares the downstream AXI4 read channel between the instruction
// fetch path (s0) and the load/store unit (s1). One read transaction is in
// flight at a time; the grant is held from the AR handshake until the R beat
// carrying rlast is accepted.
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous, active-high reset
//   s0         slave  fetch master read link
//   s1         slave  LSU master read link
//   m          master downstream read link
//   busy       out  arbiter is not idle
//   proto_err  out  sticky: rlast arrived early or late relative to arlen
module axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  axi_rd_arbiter_if.slave  s0,
  axi_rd_arbiter_if.slave  s1,
  axi_rd_arbiter_if.master m,
  output logic             busy,
  output logic             proto_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR0  = 3'd1;
  localparam logic [2:0] ST_AR1  = 3'd2;
  localparam logic [2:0] ST_R0   = 3'd3;
  localparam logic [2:0] ST_R1   = 3'd4;

  logic [2:0] state;
  logic       last_grant;
  logic [7:0] beat_cnt;
  logic [7:0] burst_len;

  logic in_ar;
  logic in_r;
  logic sel;       // owner of the current AR/R phase: 0 = s0, 1 = s1
  logic winner;
  logic r_fire;

  logic                  sel_arvalid;
  logic [ADDR_WIDTH-1:0] sel_araddr;
  logic [ID_WIDTH-1:0]   sel_arid;
  logic [DATA_WIDTH-1:0] r_data_bcast;
  logic [ID_WIDTH-1:0]   r_id_bcast;

  assign in_ar = (state == ST_AR0) || (state == ST_AR1);
  assign in_r  = (state == ST_R0)  || (state == ST_R1);
  assign sel   = (state == ST_AR1) || (state == ST_R1);
  assign busy  = (state != ST_IDLE);

  // On a tie the master that was not granted last time wins.
  assign winner = (s0.arvalid && s1.arvalid) ? ~last_grant : s1.arvalid;

  // AR path: the owner's request is forwarded combinationally.
  assign sel_arvalid = sel ? s1.arvalid : s0.arvalid;
  assign sel_araddr  = sel ? s1.araddr  : s0.araddr;
  assign sel_arid    = sel ? s1.arid    : s0.arid;

  assign m.arvalid = in_ar && sel_arvalid;
  assign m.araddr  = sel_araddr;
  assign m.arid    = sel_arid;
  assign m.arlen   = sel ? s1.arlen   : s0.arlen;
  assign m.arsize  = sel ? s1.arsize  : s0.arsize;
  assign m.arburst = sel ? s1.arburst : s0.arburst;

  assign s0.arready = in_ar && !sel && m.arready;
  assign s1.arready = in_ar &&  sel && m.arready;

  // R path: handshake routed to the owner, payload broadcast to both.
  assign m.rready  = in_r && (sel ? s1.rready : s0.rready);
  assign s0.rvalid = in_r && !sel && m.rvalid;
  assign s1.rvalid = in_r &&  sel && m.rvalid;

  assign r_data_bcast = m.rdata;
  assign r_id_bcast   = m.rid;

  assign s0.rdata = r_data_bcast;
  assign s1.rdata = r_data_bcast;
  assign s0.rid   = r_id_bcast;
  assign s1.rid   = r_id_bcast;
  assign s0.rresp = m.rresp;
  assign s1.rresp = m.rresp;
  assign s0.rlast = m.rlast;
  assign s1.rlast = m.rlast;

  assign r_fire = m.rvalid && m.rready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b0;
      proto_err  <= 1'b0;
      beat_cnt   <= 8'd0;
      burst_len  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s0.arvalid || s1.arvalid) begin
            state      <= winner ? ST_AR1 : ST_AR0;
            last_grant <= winner;
          end
        end
        ST_AR0, ST_AR1: begin
          // A withdrawn request abandons the grant without issuing anything.
          if (!m.arvalid) begin
            state <= ST_IDLE;
          end else if (m.arready) begin
            state     <= sel ? ST_R1 : ST_R0;
            burst_len <= m.arlen;
            beat_cnt  <= 8'd0;
          end
        end
        ST_R0, ST_R1: begin
          if (r_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            // rlast must coincide exactly with beat number arlen (0-based).
            if (m.rlast != (beat_cnt == burst_len)) begin
              proto_err <= 1'b1;
            end
            if (m.rlast) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

  logic clock = 1'b0;
  logic reset;
  logic busy;
  logic proto_err;

  always #5 clock = ~clock;

  axi_rd_arbiter_if s0_if ();
  axi_rd_arbiter_if s1_if ();
  axi_rd_arbiter_if m_if ();

  axi_rd_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ID_WIDTH   (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .s0        (s0_if),
    .s1        (s1_if),
    .m         (m_if),
    .busy      (busy),
    .proto_err (proto_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          delay;
    int          abort_after;
  } req_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // upstream master agents
  req_t q0[$];
  req_t q1[$];
  req_t cur[2];
  bit   act[2];
  int   wait_c[2];
  int   asrt[2];
  // knobs
  int   rr_pct, rv_pct, ar_pct, ar_delay;
  bit   early_knob;
  // downstream slave agent
  bit         ds_busy, ds_rv, ds_early;
  int         ds_beat;
  logic [7:0] ds_len;
  logic [3:0] ds_id;
  int         ar_hold, last_ar_wait;
  // handshakes seen in the last observed cycle
  bit         f_mar, f_mr, f_rlast;
  bit         f_sar[2];
  logic [7:0] f_len;
  logic [3:0] f_id;
  // reference model
  int         mdl_holder;
  bit         mdl_data, mdl_last, mdl_perr;
  int         mdl_beats, mdl_len;
  logic [3:0] mdl_id;
  int         beats_rx[2];
  int         grant_log[$];
  int         n_mar;

  function automatic logic s_arvalid(input int i);
    return (i == 1) ? s1_if.arvalid : s0_if.arvalid;
  endfunction

  function automatic logic s_rready(input int i);
    return (i == 1) ? s1_if.rready : s0_if.rready;
  endfunction

  function automatic req_t mk(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                              input int dly, input int ab);
    req_t r;
    r.addr = a; r.id = id; r.len = len; r.size = 3'($urandom_range(5));
    r.burst = 2'($urandom_range(2)); r.delay = dly; r.abort_after = ab;
    return r;
  endfunction

  task automatic drive_master(input int i, input logic av, input req_t r, input logic rr);
    if (i == 1) begin
      s1_if.arvalid = av; s1_if.araddr = r.addr; s1_if.arid = r.id; s1_if.arlen = r.len;
      s1_if.arsize = r.size; s1_if.arburst = r.burst; s1_if.rready = rr;
    end else begin
      s0_if.arvalid = av; s0_if.araddr = r.addr; s0_if.arid = r.id; s0_if.arlen = r.len;
      s0_if.arsize = r.size; s0_if.arburst = r.burst; s0_if.rready = rr;
    end
  endtask

  task automatic set_knobs(input int rr, input int rv, input int ar, input int ard);
    rr_pct = rr; rv_pct = rv; ar_pct = ar; ar_delay = ard;
  endtask

  task automatic clear_env();
    req_t z;
    z = mk(32'h0, 4'h0, 8'h0, 0, 0);
    drive_master(0, 1'b0, z, 1'b0);
    drive_master(1, 1'b0, z, 1'b0);
    m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rresp = 2'b00;
    m_if.rlast = 1'b0; m_if.rid = '0;
    q0.delete(); q1.delete(); grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; wait_c[i] = 0; asrt[i] = 0; f_sar[i] = 0; beats_rx[i] = 0; cur[i] = z;
    end
    ds_busy = 0; ds_rv = 0; ds_early = 0; ds_beat = 0; ar_hold = 0; last_ar_wait = 0;
    f_mar = 0; f_mr = 0; f_rlast = 0; early_knob = 0; n_mar = 0;
    mdl_holder = -1; mdl_data = 0; mdl_last = 0; mdl_perr = 0; mdl_beats = 0;
  endtask

  task automatic observe();
    int         h;
    logic       av;
    logic [5:0] hs;
    logic [5:0] e;
    hs = {m_if.arvalid, s0_if.arready, s1_if.arready, s0_if.rvalid, s1_if.rvalid, m_if.rready};
    f_mar = m_if.arvalid && m_if.arready;
    f_mr = m_if.rvalid && m_if.rready;
    f_sar[0] = s0_if.arvalid && s0_if.arready;
    f_sar[1] = s1_if.arvalid && s1_if.arready;
    f_rlast = m_if.rlast; f_len = m_if.arlen; f_id = m_if.arid;
    check("busy", busy, mdl_holder >= 0);
    check("proto_err", proto_err, mdl_perr);
    check("bcast_s0", {s0_if.rdata, s0_if.rresp, s0_if.rlast, s0_if.rid},
          {m_if.rdata, m_if.rresp, m_if.rlast, m_if.rid});
    check("bcast_s1", {s1_if.rdata, s1_if.rresp, s1_if.rlast, s1_if.rid},
          {m_if.rdata, m_if.rresp, m_if.rlast, m_if.rid});
    if (mdl_holder < 0) begin
      check("idle_hs", hs, 6'b0);
      if (s0_if.arvalid || s1_if.arvalid) begin
        h = (s0_if.arvalid && s1_if.arvalid) ? (mdl_last ? 0 : 1) : (s1_if.arvalid ? 1 : 0);
        mdl_holder = h; mdl_last = (h == 1); mdl_data = 0;
      end
    end else if (!mdl_data) begin
      h = mdl_holder;
      av = s_arvalid(h);
      e = 6'b0; e[5] = av;
      if (h == 0) e[4] = m_if.arready; else e[3] = m_if.arready;
      check("ar_hs", hs, e);
      if (av) check("ar_fields", {m_if.araddr, m_if.arid, m_if.arlen, m_if.arsize, m_if.arburst},
                    {cur[h].addr, cur[h].id, cur[h].len, cur[h].size, cur[h].burst});
      if (av && m_if.arready) begin
        mdl_data = 1; mdl_beats = 0; mdl_len = int'(cur[h].len); mdl_id = cur[h].id;
        grant_log.push_back(h); n_mar++; last_ar_wait = ar_hold + 1;
      end else if (!av) begin
        mdl_holder = -1;
      end
    end else begin
      h = mdl_holder;
      e = 6'b0; e[0] = s_rready(h);
      if (h == 0) e[2] = m_if.rvalid; else e[1] = m_if.rvalid;
      check("r_hs", hs, e);
      if (m_if.rvalid && s_rready(h)) begin
        mdl_beats++; beats_rx[h]++;
        check("rid", m_if.rid, mdl_id);
        if (m_if.rlast != (mdl_beats == mdl_len + 1)) mdl_perr = 1;
        if (m_if.rlast) mdl_holder = -1;
      end
    end
    if (m_if.arvalid && !m_if.arready) ar_hold++; else ar_hold = 0;
  endtask

  task automatic step();
    logic av;
    bit   fresh;
    @(negedge clock);
    for (int i = 0; i < 2; i++) if (f_sar[i]) act[i] = 0;
    if (f_mar) begin
      ds_busy = 1; ds_beat = 0; ds_rv = 0; ds_len = f_len; ds_id = f_id;
      ds_early = early_knob; early_knob = 0;
    end
    if (f_mr) begin
      ds_rv = 0; ds_beat++;
      if (f_rlast) ds_busy = 0;
    end
    for (int i = 0; i < 2; i++) begin
      fresh = 0;
      if (!act[i]) begin
        if (i == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); fresh = 1; end
        if (i == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); fresh = 1; end
        if (fresh) begin act[i] = 1; wait_c[i] = cur[i].delay; asrt[i] = 0; end
      end
      av = 1'b0;
      if (act[i]) begin
        if (wait_c[i] > 0) wait_c[i]--;
        else if (cur[i].abort_after > 0 && asrt[i] == cur[i].abort_after) act[i] = 0;
        else begin av = 1'b1; asrt[i]++; end
      end
      drive_master(i, av, cur[i], $urandom_range(99) < rr_pct);
    end
    m_if.arready = (ar_hold >= ar_delay) && ($urandom_range(99) < ar_pct);
    if (ds_busy) begin
      if (!ds_rv && $urandom_range(99) < rv_pct) begin
        ds_rv = 1;
        m_if.rdata = $urandom; m_if.rresp = 2'($urandom_range(3)); m_if.rid = ds_id;
        m_if.rlast = ds_early || (ds_beat == int'(ds_len));
      end
    end else begin
      ds_rv = 0;
    end
    m_if.rvalid = ds_rv;
    #1;
    observe();
  endtask

  task automatic run(input int max_cyc, input int stop_beats0);
    int idle_run = 0;
    for (int n = 0; n < max_cyc; n++) begin
      step();
      if (stop_beats0 > 0) begin
        if (beats_rx[0] >= stop_beats0) return;
      end else begin
        if (q0.size() == 0 && q1.size() == 0 && !act[0] && !act[1] && mdl_holder < 0 && !busy)
          idle_run++;
        else
          idle_run = 0;
        if (idle_run >= 3) return;
      end
    end
    check("timeout_idle_run", idle_run, 3);
  endtask

  task automatic apply_reset(input bit check_now);
    @(negedge clock);
    reset = 1'b1;
    #1;
    if (check_now)
      check("rst_outs", {busy, proto_err, m_if.arvalid, s0_if.arready, s1_if.arready,
                         s0_if.rvalid, s1_if.rvalid, m_if.rready}, 8'h00);
    clear_env();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int exp0, exp1, nreq;
    logic [5:0] g;
    reset = 1'b1;
    clear_env();
    set_knobs(100, 100, 100, 0);
    repeat (2) @(negedge clock);
    #1;
    check("reset_state", {busy, proto_err, m_if.arvalid, s0_if.arready, s1_if.arready,
                          s0_if.rvalid, s1_if.rvalid, m_if.rready}, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // 1: single fetch request, 4 beats
    q0.push_back(mk(32'h3000_0000, 4'h5, 8'd3, 0, 0));
    run(200, 0);
    check("t1_s0_beats", beats_rx[0], 4);
    check("t1_s1_beats", beats_rx[1], 0);
    check("t1_grants", grant_log.size(), 1);

    // 2: simultaneous first requests, LSU wins
    apply_reset(0);
    q0.push_back(mk(32'h1000_0040, 4'h1, 8'd2, 0, 0));
    q1.push_back(mk(32'h2000_0080, 4'h2, 8'd1, 0, 0));
    run(200, 0);
    check("t2_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) check("t2_order", {grant_log[0][0], grant_log[1][0]}, 2'b10);

    // 3: continuous contention alternates
    apply_reset(0);
    for (int k = 0; k < 3; k++) begin
      q0.push_back(mk($urandom, 4'($urandom), 8'($urandom_range(4)), 0, 0));
      q1.push_back(mk($urandom, 4'($urandom), 8'($urandom_range(4)), 0, 0));
    end
    run(400, 0);
    check("t3_grants", grant_log.size(), 6);
    g = 6'b0;
    for (int k = 0; k < grant_log.size() && k < 6; k++) g[k] = grant_log[k][0];
    check("t3_order", g, 6'b010101);

    // 4: downstream AR stall and R backpressure
    apply_reset(0);
    set_knobs(50, 100, 100, 5);
    q0.push_back(mk(32'h4000_0100, 4'h3, 8'd7, 0, 0));
    run(300, 0);
    check("t4_ar_wait", last_ar_wait, 6);
    check("t4_s0_beats", beats_rx[0], 8);

    // 5: early rlast, then reset mid-burst
    apply_reset(0);
    set_knobs(100, 100, 100, 0);
    early_knob = 1;
    q0.push_back(mk(32'h5000_0000, 4'h6, 8'd1, 0, 0));
    run(200, 0);
    check("t5_perr", proto_err, 1'b1);
    check("t5_busy", busy, 1'b0);
    q0.push_back(mk(32'h5000_0200, 4'h7, 8'd7, 0, 0));
    run(200, beats_rx[0] + 3);
    check("t5_mid_busy", busy, 1'b1);
    apply_reset(1);
    q0.push_back(mk(32'h5000_0400, 4'h8, 8'd0, 0, 0));
    q1.push_back(mk(32'h5000_0800, 4'h9, 8'd0, 0, 0));
    run(200, 0);
    if (grant_log.size() > 0) check("t5_post_rst_first", grant_log[0], 1);
    else check("t5_post_rst_grants", grant_log.size(), 2);

    // 6: fetch withdraws before AR handshake, LSU served afterwards
    apply_reset(0);
    set_knobs(100, 100, 100, 3);
    q0.push_back(mk(32'h6000_0000, 4'hA, 8'd2, 0, 2));
    q1.push_back(mk(32'h6000_1000, 4'hB, 8'd2, 2, 0));
    run(300, 0);
    check("t6_ar_count", n_mar, 1);
    if (grant_log.size() > 0) check("t6_granted", grant_log[0], 1);
    check("t6_s0_beats", beats_rx[0], 0);
    check("t6_s1_beats", beats_rx[1], 3);

    // 7: randomized traffic including a 256-beat burst
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset(0);
      set_knobs($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100), 0);
      exp0 = 0; exp1 = 0; nreq = 0;
      if (pass == 0) begin
        q0.push_back(mk($urandom, 4'($urandom), 8'd255, 0, 0));
        exp0 += 256; nreq++;
      end
      for (int k = 0; k < 10; k++) begin
        q0.push_back(mk($urandom, 4'($urandom), 8'($urandom_range(15)), $urandom_range(6), 0));
        exp0 += int'(q0[q0.size()-1].len) + 1;
        q1.push_back(mk($urandom, 4'($urandom), 8'($urandom_range(15)), $urandom_range(6), 0));
        exp1 += int'(q1[q1.size()-1].len) + 1;
        nreq += 2;
      end
      run(20000, 0);
      check("t7_s0_beats", beats_rx[0], exp0);
      check("t7_s1_beats", beats_rx[1], exp1);
      check("t7_ar_count", n_mar, nreq);
      check("t7_perr", proto_err, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
